// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: default sizing and
// the FSM state encoding.
package uart_pkg;

  localparam int DEFAULT_DATA_W       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

endpackage

// File: rtl/fifo_16x8.sv
// Small synchronous FIFO with a registered read port: data_out is valid the
// cycle after a read enable is accepted.
module fifo_16x8 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_wr = we && !full;
  assign do_rd = re && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage and read data carry no reset; only pointers and count do.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
    if (do_rd) data_out <= mem[rd_ptr];
  end

endmodule

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: tick is high on the last clk cycle of each bit period.
// clr restarts the period so every state begins on a fresh bit boundary.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a synchronous FIFO and serialises each as a UART frame:
// start bit, DATA_W data bits LSB first, optional even parity, one stop bit.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_re,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t            state;
  state_t            next_state;
  logic              tick;
  logic              baud_clr;
  logic              last_bit;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              tx_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (tick)
  );

  assign last_bit = (bit_cnt == LAST_BIT);
  assign tx       = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    fifo_re    = 1'b0;
    busy       = 1'b1;
    byte_done  = 1'b0;
    baud_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (tx_en && !fifo_empty) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        fifo_re    = 1'b1;
        next_state = ST_LOAD;
      end
      ST_LOAD: begin
        next_state = ST_START;
      end
      ST_START: begin
        if (tick) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (tick && last_bit) next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (tick) next_state = ST_STOP;
      end
      ST_STOP: begin
        byte_done = tick;
        if (tick) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    // Hold the timer at zero until the first serial bit so START gets a full period.
    baud_clr = (next_state != state) || (state == ST_IDLE) ||
               (state == ST_FETCH) || (state == ST_LOAD);
  end

  // tx is loaded with the value of the bit about to begin, so it only moves on
  // the edge where a new bit period starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q    <= 1'b1;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          tx_q    <= 1'b0;
          bit_cnt <= '0;
        end
        ST_START: begin
          if (tick) tx_q <= shreg[0];
        end
        ST_DATA: begin
          if (tick) begin
            if (last_bit) begin
              tx_q <= (PARITY_EN != 0) ? par_bit : 1'b1;
            end else begin
              tx_q    <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) tx_q <= 1'b1;
        end
        default: begin
          tx_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_LOAD) begin
      shreg   <= fifo_data;
      par_bit <= even_parity(fifo_data);
    end else if ((state == ST_DATA) && tick && !last_bit) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx fed from real FIFOs; one transmitter without parity
// and one with, with a line-decoding monitor checking frames against a scoreboard.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [10:0] frame;
    bit          gap_chk;
  } exp_t;

  logic clk;
  logic rst;

  logic       we_a, we_b;
  logic [7:0] din_a, din_b;
  logic       tx_en_a, tx_en_b;
  logic [7:0] dout_a, dout_b;
  logic       empty_a, empty_b, full_a, full_b;
  logic [4:0] count_a, count_b;
  logic       fifo_re_a, fifo_re_b;
  logic       tx_a, tx_b, busy_a, busy_b, bd_a, bd_b;

  bit   phase6;
  logic mon_tx, mon_bd;
  assign mon_tx = phase6 ? tx_b : tx_a;
  assign mon_bd = phase6 ? bd_b : bd_a;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  fifo_16x8 #(.DATA_W(8), .DEPTH(16)) u_fifo_a (
    .clk(clk), .rst(rst), .we(we_a), .din(din_a), .re(fifo_re_a),
    .data_out(dout_a), .empty(empty_a), .full(full_a), .count(count_a)
  );

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut_a (
    .clk(clk), .rst(rst), .tx_en(tx_en_a), .fifo_empty(empty_a), .fifo_data(dout_a),
    .fifo_re(fifo_re_a), .tx(tx_a), .busy(busy_a), .byte_done(bd_a)
  );

  fifo_16x8 #(.DATA_W(8), .DEPTH(16)) u_fifo_b (
    .clk(clk), .rst(rst), .we(we_b), .din(din_b), .re(fifo_re_b),
    .data_out(dout_b), .empty(empty_b), .full(full_b), .count(count_b)
  );

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut_b (
    .clk(clk), .rst(rst), .tx_en(tx_en_b), .fifo_empty(empty_b), .fifo_data(dout_b),
    .fifo_re(fifo_re_b), .tx(tx_b), .busy(busy_b), .byte_done(bd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: decode the serial line one sample per cycle and score each frame.
  bit          mon_active = 0;
  int          samp, bitidx, nbits, gap;
  int          idle_run = 0;
  logic        bitval, holdbad, bdbad, is_last;
  logic [10:0] fr;
  exp_t        e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 0;
        idle_run   = 0;
      end else begin
        if (!mon_active && mon_tx === 1'b0) begin
          mon_active = 1;
          samp    = 0;
          bitidx  = 0;
          fr      = '0;
          holdbad = 1'b0;
          bdbad   = 1'b0;
          gap     = idle_run;
          nbits   = phase6 ? 11 : 10;
        end
        if (!mon_active) begin
          if (idle_run < 100000) idle_run++;
        end else begin
          if (samp == 0) bitval = mon_tx;
          else if (mon_tx !== bitval) holdbad = 1'b1;
          is_last = (bitidx == nbits - 1) && (samp == CPB - 1);
          if (mon_bd !== is_last) bdbad = 1'b1;
          samp++;
          if (samp == CPB) begin
            fr[bitidx] = bitval;
            samp = 0;
            bitidx++;
          end
          if (bitidx == nbits) begin
            mon_active = 0;
            idle_run   = 0;
            if (sb.size() == 0) begin
              n_checks++;
              $display("FAIL frame_unexpected: got 0x%0h, expected no frame", fr);
            end else begin
              e = sb.pop_front();
              check("frame", 32'(fr), 32'(e.frame));
              check("bit_hold", 32'(holdbad), 32'd0);
              check("byte_done_pos", 32'(bdbad), 32'd0);
              if (e.gap_chk) check("stop_to_start_gap", gap, 32'd3);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [10:0] f, input bit g);
    exp_t x;
    x.frame   = f;
    x.gap_chk = g;
    sb.push_back(x);
  endtask

  task automatic write_fifo(input bit sel, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin we_b = 1'b1; din_b = d; end
    else     begin we_a = 1'b1; din_a = d; end
    @(negedge clk);
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int t = 0;
    while ((sb.size() != 0 || mon_active) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d frames outstanding, expected 0", name, sb.size());
    end
  endtask

  task automatic wait_re(input bit sel, input string name, output bit ok);
    int t = 0;
    ok = 1'b0;
    while (!ok && t < 40) begin
      @(negedge clk);
      if ((sel ? fifo_re_b : fifo_re_a) === 1'b1) ok = 1'b1;
      t++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s_timeout: got no fifo_re, expected a pulse", name);
    end
  endtask

  initial begin
    int n_busy, n_re, n_bd, t;
    bit ok, any_re, any_low, any_busy;

    rst = 1'b1;
    we_a = 1'b0; we_b = 1'b0; din_a = '0; din_b = '0;
    tx_en_a = 1'b0; tx_en_b = 1'b0; phase6 = 1'b0;

    // 1: reset outputs on every reset cycle
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_outputs_a", {tx_a, fifo_re_a, busy_a, bd_a}, 4'b1000);
      check("reset_outputs_b", {tx_b, fifo_re_b, busy_b, bd_b}, 4'b1000);
    end
    rst = 1'b0;

    // 2: single byte 0xA5
    write_fifo(0, 8'hA5);
    push_exp(11'h34A, 0);
    tx_en_a = 1'b1;
    n_busy = 0; n_re = 0; n_bd = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy_a) n_busy++;
      if (fifo_re_a) n_re++;
      if (bd_a) n_bd++;
    end
    check("t2_busy_cycles", n_busy, 32'd42);
    check("t2_fifo_re_pulses", n_re, 32'd1);
    check("t2_byte_done_pulses", n_bd, 32'd1);
    wait_done("t2", 200);

    // 3: three back-to-back frames
    tx_en_a = 1'b0;
    write_fifo(0, 8'h00);
    write_fifo(0, 8'hFF);
    write_fifo(0, 8'h3C);
    check("t3_fifo_not_full", 32'(full_a), 32'd0);
    push_exp(11'h200, 0);
    push_exp(11'h3FE, 1);
    push_exp(11'h278, 1);
    tx_en_a = 1'b1;
    n_re = 0; t = 0;
    while (n_re < 3 && t < 500) begin
      @(negedge clk);
      if (fifo_re_a) n_re++;
      t++;
    end
    if (n_re < 3) begin
      n_checks++;
      $display("FAIL t3_fetch_timeout: got %0d fifo_re pulses, expected 3", n_re);
    end else begin
      @(negedge clk);
      check("t3_empty_after_third_read", 32'(empty_a), 32'd1);
    end
    wait_done("t3", 500);

    // 4: empty FIFO with tx_en held high
    any_re = 0; any_low = 0; any_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_re_a !== 1'b0) any_re = 1;
      if (tx_a !== 1'b1) any_low = 1;
      if (busy_a !== 1'b0) any_busy = 1;
    end
    check("t4_fifo_re_quiet", 32'(any_re), 32'd0);
    check("t4_tx_idle_high", 32'(any_low), 32'd0);
    check("t4_busy_low", 32'(any_busy), 32'd0);

    // 5: drop tx_en during data bit 2 of the first frame
    tx_en_a = 1'b0;
    write_fifo(0, 8'h81);
    write_fifo(0, 8'h42);
    push_exp(11'h302, 0);
    tx_en_a = 1'b1;
    wait_re(0, "t5_first_fetch", ok);
    if (ok) begin
      repeat (15) @(negedge clk);
      tx_en_a = 1'b0;
      n_re = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (fifo_re_a) n_re++;
      end
      check("t5_no_second_fetch", n_re, 32'd0);
      check("t5_fifo_count", 32'(count_a), 32'd1);
    end
    wait_done("t5", 200);

    // 6: parity instance, mid-frame reset, then clean frame
    phase6 = 1'b1;
    write_fifo(1, 8'h07);
    push_exp(11'h60E, 0);
    tx_en_b = 1'b1;
    wait_done("t6_parity", 200);
    write_fifo(1, 8'h33);
    wait_re(1, "t6_interrupt_fetch", ok);
    if (ok) begin
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_tx_after_reset", 32'(tx_b), 32'd1);
      check("t6_busy_after_reset", 32'(busy_b), 32'd0);
      rst = 1'b0;
    end
    write_fifo(1, 8'h5A);
    push_exp(11'h4B4, 0);
    wait_done("t6_clean", 200);
    check("t6_fifo_drained", 32'(count_b), 32'd0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
